// File: rtl/stop_watch_pkg.sv
// Shared constants for the stopwatch button sequencer: FSM encoding and
// the debounce defaults used on hardware.
package stop_watch_pkg;

  localparam int DB_CYCLES_DEFAULT = 2000000;
  localparam int DB_W_DEFAULT      = 21;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;
  localparam logic [1:0] ST_LAP  = 2'd3;

  // The counter is enabled in both running states; a lap only freezes the display.
  function automatic logic is_counting(input state_t st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/stop_watch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its surroundings
// (buttons, digit counter, display multiplexer).
interface stop_watch_ctrl_if;

  logic       btn_ss;
  logic       btn_lc;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       go;
  logic       clr;
  logic [3:0] disp3;
  logic [3:0] disp2;
  logic [3:0] disp1;
  logic [3:0] disp0;
  logic       running;
  logic       lap_active;

  modport slave (
    input  btn_ss, btn_lc, d3, d2, d1, d0,
    output go, clr, disp3, disp2, disp1, disp0, running, lap_active
  );

  modport master (
    output btn_ss, btn_lc, d3, d2, d1, d0,
    input  go, clr, disp3, disp2, disp1, disp0, running, lap_active
  );

endinterface

// File: rtl/stop_watch_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each filtered 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_p
);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // The level only flips once the disagreement has persisted past DB_CYCLES
  // counts, which yields a raw-to-level latency of 2 + DB_CYCLES edges.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q + DB_W'(1);
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DB_CYCLES)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level  = level_q;
  assign rise_p = level_q & ~level_prev_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch sequencer: debounced start/stop and lap/clear buttons drive a
// 4-state FSM that controls the digit counter and freezes the display on lap.
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  stop_watch_ctrl_if.slave  bus
);

  logic [1:0]  btn_raw;
  logic [1:0]  btn_level;
  logic [1:0]  btn_rise;
  logic        ss_p;
  logic        lc_p;

  state_t      state_q;
  state_t      state_d;
  logic        go_q;
  logic        go_d;
  logic        clr_q;
  logic        clr_d;
  logic [15:0] lap_q;
  logic [15:0] lap_d;
  logic [15:0] live_digits;

  assign btn_raw     = {bus.btn_lc, bus.btn_ss};
  assign live_digits = {bus.d3, bus.d2, bus.d1, bus.d0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
      ) u_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw[gi]),
        .level   (btn_level[gi]),
        .rise_p  (btn_rise[gi])
      );
    end
  endgenerate

  assign ss_p = btn_rise[0] & btn_level[0];
  assign lc_p = btn_rise[1] & btn_level[1];

  // Start/stop has priority: a simultaneous lap/clear press is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    lap_d   = lap_q;
    if (ss_p) begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  state_d = ST_STOP;
        ST_LAP:  state_d = ST_STOP;
        ST_STOP: state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end else if (lc_p) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        ST_RUN: begin
          state_d = ST_LAP;
          lap_d   = live_digits;
        end
        ST_LAP:  state_d = ST_RUN;
        ST_STOP: begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    go_d = is_counting(state_d);
  end

  // clr is raised out of reset because the digit counter has no reset of its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      clr_q   <= 1'b1;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  always_comb begin
    if (state_q == ST_LAP) begin
      {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = lap_q;
    end else begin
      {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = live_digits;
    end
  end

  assign bus.go         = go_q;
  assign bus.clr        = clr_q;
  assign bus.running    = is_counting(state_q);
  assign bus.lap_active = (state_q == ST_LAP);

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Randomised bench for stop_watch_ctrl, checked every cycle against a
// sample-history / mode-level reference model of the button sequencer.
module tb_stop_watch_ctrl;

  localparam int DB  = 4;
  localparam int HL  = DB + 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_LAP  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stop_watch_ctrl_if bus ();

  stop_watch_ctrl #(
    .DB_CYCLES (DB),
    .DB_W      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a button's filtered level flips when the raw samples
  // taken 2+DB .. 2 edges ago all disagree with it; the FSM sees the rise
  // one edge later.
  bit          m_valid = 1'b0;
  int          m_mode;
  bit          m_go;
  bit          m_clr;
  logic [15:0] m_lap;
  bit          filt [2];
  bit          pend [2];
  bit          hist [2][HL];
  bit          raws [2];
  bit          ss_p_m, lc_p_m, clr_m, all_diff;
  int          nxt;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_mode  = M_IDLE;
      m_go    = 1'b0;
      m_clr   = 1'b1;
      m_lap   = 16'h0;
      for (int b = 0; b < 2; b++) begin
        filt[b] = 1'b0;
        pend[b] = 1'b0;
        for (int j = 0; j < HL; j++) hist[b][j] = 1'b0;
      end
    end else begin
      ss_p_m = pend[0];
      lc_p_m = pend[1];
      clr_m  = 1'b0;
      nxt    = m_mode;
      if (ss_p_m) begin
        nxt = (m_mode == M_RUN || m_mode == M_LAP) ? M_STOP : M_RUN;
      end else if (lc_p_m) begin
        if (m_mode == M_IDLE || m_mode == M_STOP) begin
          nxt   = M_IDLE;
          clr_m = 1'b1;
        end else if (m_mode == M_RUN) begin
          nxt   = M_LAP;
          m_lap = {bus.d3, bus.d2, bus.d1, bus.d0};
        end else begin
          nxt = M_RUN;
        end
      end
      m_mode = nxt;
      m_go   = (nxt == M_RUN || nxt == M_LAP);
      m_clr  = clr_m;

      raws[0] = bus.btn_ss;
      raws[1] = bus.btn_lc;
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < HL - 1; j++) hist[b][j] = hist[b][j+1];
        hist[b][HL-1] = raws[b];
        pend[b]  = 1'b0;
        all_diff = 1'b1;
        for (int j = 0; j <= DB; j++) if (hist[b][j] == filt[b]) all_diff = 1'b0;
        if (all_diff) begin
          filt[b] = ~filt[b];
          pend[b] = filt[b];
        end
      end
    end
  end

  logic [15:0] exp_disp;
  always @(negedge clk) begin
    if (m_valid) begin
      exp_disp = (m_mode == M_LAP) ? m_lap : {bus.d3, bus.d2, bus.d1, bus.d0};
      check_val("go", 32'(bus.go), 32'(m_go));
      check_val("clr", 32'(bus.clr), 32'(m_clr));
      check_val("running", 32'(bus.running), 32'(m_mode == M_RUN || m_mode == M_LAP));
      check_val("lap_active", 32'(bus.lap_active), 32'(m_mode == M_LAP));
      check_val("disp", 32'({bus.disp3, bus.disp2, bus.disp1, bus.disp0}), 32'(exp_disp));
    end
  end

  bit d_rand = 1'b1;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      if (d_rand) begin
        bus.d3 = 4'($urandom_range(0, 9));
        bus.d2 = 4'($urandom_range(0, 9));
        bus.d1 = 4'($urandom_range(0, 9));
        bus.d0 = 4'($urandom_range(0, 9));
      end
    end
  endtask

  task automatic set_d(input logic [15:0] v);
    {bus.d3, bus.d2, bus.d1, bus.d0} = v;
  endtask

  // which: bit0 = start/stop, bit1 = lap/clear; bounce adds random chatter first.
  task automatic press(input logic [1:0] which, input int hold, input bit bounce);
    if (bounce) begin
      repeat ($urandom_range(1, 3)) begin
        bus.btn_ss = which[0] & 1'($urandom);
        bus.btn_lc = which[1] & 1'($urandom);
        tick(1);
      end
    end
    bus.btn_ss = which[0];
    bus.btn_lc = which[1];
    tick(hold);
    bus.btn_ss = 1'b0;
    bus.btn_lc = 1'b0;
    tick(DB + 5);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  int act;

  initial begin
    reset      = 1'b1;
    bus.btn_ss = 1'b0;
    bus.btn_lc = 1'b0;
    set_d(16'h0000);
    tick(2);
    reset = 1'b0;
    $display("[TB] txn reset 2 cycles");
    tick(3);

    $display("[TB] txn ss glitch 3 cycles");
    bus.btn_ss = 1'b1; tick(3); bus.btn_ss = 1'b0; tick(8);
    $display("[TB] txn ss hold 10 -> RUN");
    press(2'b01, 10, 1'b0);

    d_rand = 1'b0;
    set_d(16'h1234);
    $display("[TB] txn lc -> LAP at 1234");
    press(2'b10, 8, 1'b0);
    set_d(16'h1240);
    tick(4);
    $display("[TB] txn lc -> RUN");
    press(2'b10, 8, 1'b0);
    d_rand = 1'b1;

    $display("[TB] txn ss -> STOP, lc -> IDLE clr");
    press(2'b01, 8, 1'b0);
    press(2'b10, 8, 1'b0);
    $display("[TB] txn ss -> RUN, both -> STOP");
    press(2'b01, 8, 1'b0);
    press(2'b11, 8, 1'b0);
    $display("[TB] txn ss -> RUN, lc -> LAP, reset");
    press(2'b01, 8, 1'b0);
    press(2'b10, 8, 1'b0);
    do_reset(1);
    tick(4);

    for (int i = 0; i < 150; i++) begin
      act = $urandom_range(0, 19);
      if (act < 7) begin
        $display("[TB] txn %0d press ss", i);
        press(2'b01, $urandom_range(6, 12), 1'($urandom));
      end else if (act < 14) begin
        $display("[TB] txn %0d press lc", i);
        press(2'b10, $urandom_range(6, 12), 1'($urandom));
      end else if (act < 16) begin
        $display("[TB] txn %0d press both", i);
        press(2'b11, $urandom_range(6, 12), 1'b0);
      end else if (act < 18) begin
        $display("[TB] txn %0d glitch", i);
        bus.btn_ss = 1'($urandom);
        bus.btn_lc = 1'($urandom);
        tick($urandom_range(1, DB));
        bus.btn_ss = 1'b0;
        bus.btn_lc = 1'b0;
        tick(DB + 4);
      end else if (act < 19) begin
        $display("[TB] txn %0d idle", i);
        tick($urandom_range(1, 10));
      end else begin
        $display("[TB] txn %0d reset", i);
        do_reset($urandom_range(1, 2));
        tick(2);
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stop_watch_ctrl.md
Name: stop_watch_ctrl

Overview:
Button-driven sequencer for the 4-digit stopwatch counter (digits d3 d2 d1 d0, format M:SS.t, 0.1 s resolution). It debounces two raw push-buttons and runs a 4-state FSM that drives the counter's go/clr inputs. It also holds a lap (split) capture that freezes the displayed digits while the counter keeps running. The block sits between board buttons, the counter, and the 7-segment display multiplexer.

Parameters:
DB_CYCLES, 2000000, clock cycles a synchronised button level must stay stable before the filtered level changes (20 ms at 100 MHz; set to 4 in simulation).
DB_W, 21, width of the debounce counter; must satisfy 2**DB_W > DB_CYCLES.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  synchronous, active-high reset.
btn_ss  in  1  raw start/stop button, asynchronous, active-high.
btn_lc  in  1  raw lap/clear button, asynchronous, active-high.
d3, d2, d1, d0  in  4 each  live BCD digits from the counter.
go  out  1  counter enable.
clr  out  1  counter clear, one-cycle pulse.
disp3, disp2, disp1, disp0  out  4 each  digits to the display (live or lap-frozen).
running  out  1  high in RUN or LAP.
lap_active  out  1  high in LAP.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Button path, per button:
  - 2-FF synchroniser, then a debounce counter, then a rising-edge pulse.
  - Counter resets to 0 whenever the synchronised level equals the filtered level. Otherwise it increments.
  - When the counter would reach DB_CYCLES, the filtered level takes the synchronised value and the counter returns to 0.
  - Pulse ss_p / lc_p is high for exactly one cycle on a 0->1 filtered transition. A 1->0 transition produces no pulse.
  - Bounces shorter than DB_CYCLES produce no pulse.
  - Exact latency: if edge k is the first edge sampling raw=1, the filtered level rises at edge k+2+DB_CYCLES, and the pulse is visible in the following cycle.
- FSM states: IDLE, RUN, STOP, LAP. Encoding is held in the package.
  - IDLE: ss_p -> RUN. lc_p -> IDLE and issue clr.
  - RUN: ss_p -> STOP. lc_p -> LAP and capture lap_reg <= {d3,d2,d1,d0} on that edge.
  - LAP: ss_p -> STOP (lap released, display returns to live). lc_p -> RUN (lap released).
  - STOP: ss_p -> RUN. lc_p -> IDLE and issue clr.
  - ss_p and lc_p in the same cycle: ss_p wins and lc_p is discarded.
- go: registered, equal to (next_state is RUN or LAP). It therefore changes on the same edge as the state, and the counter runs exactly while the state is RUN or LAP.
- clr: registered one-cycle pulse on the edge of a clr-issuing transition. go is 0 in that cycle.
- disp*: lap_reg when state is LAP, otherwise d* passthrough (combinational mux).
- running and lap_active: decoded from the state register.
- Reset values:
  - state IDLE, go=0, lap_reg=0, debounce counters 0, filtered levels 0, synchroniser FFs 0.
  - clr=1 in the cycle after the reset edge. This clears the counter, which has no reset of its own. clr returns to 0 on the first edge with reset low.
- Reset asserted mid-RUN or mid-LAP: next edge gives IDLE, go=0, clr=1, and the lap is discarded.
- A held button generates only one pulse. Re-pressing requires a release that is filtered (stable 0 for DB_CYCLES).

Decomposition:
- Package stop_watch_pkg holds:
  - state typedef/localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2, ST_LAP=2'd3;
  - the default DB_CYCLES constant.
- One sub-module, btn_debounce (params DB_CYCLES, DB_W; ports clk, reset, btn_raw, level, rise_p), instantiated twice.
- FSM, lap register and display mux live in stop_watch_ctrl.

Test Plan (DB_CYCLES=4):
1. Reset for 2 cycles, then release -> clr=1 in exactly one cycle after the reset edge, go=0, state IDLE, disp = d inputs.
2. btn_ss glitch high for 3 cycles -> no ss_p, go stays 0. btn_ss held 10 cycles -> one ss_p at edge k+6+1, go=1, running=1.
3. In RUN with d=1,2,3,4, press btn_lc -> lap_active=1, disp frozen at 1,2,3,4 while d advances to 1,2,4,0, go remains 1. Press btn_lc again -> RUN, disp tracks d.
4. RUN, press btn_ss -> STOP, go=0. Press btn_lc -> IDLE, clr pulse of exactly 1 cycle, go=0.
5. btn_ss and btn_lc rise in the same cycle while in RUN -> STOP, no lap capture, lap_active=0.
6. Assert reset while in LAP -> next edge: IDLE, go=0, clr=1, lap_active=0, disp = live d.
